// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI register-access master.
package spi_pkg;

    // Frame sequencer states, in the order a frame walks through them.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HEADER,
        ST_DATA,
        ST_HOLD,
        ST_DONE
    } state_t;

    // Command direction encoding on i_rw.
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Number of serial bits in one frame: R/W bit, address, then all data words.
    function automatic int frame_bits(input int addr_w, input int data_w, input int words);
        return 1 + addr_w + words * data_w;
    endfunction

endpackage

// File: rtl/spi_bit_timer.sv
// Bit-period divider: generates the serial clock and the per-bit strobes
// while enabled; counter and SCK are parked at zero when disabled.
module spi_bit_timer #(
    parameter int CLKS_PER_BIT = 30
) (
    input  logic i_clock,
    input  logic i_resetN,
    input  logic en,
    output logic sck,
    output logic sample_strobe,
    output logic pre_end,
    output logic bit_end
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    logic [CNT_W-1:0] cnt_reg;

    // Count through one bit period; SCK is low for the first half, high for the second.
    always_ff @(posedge i_clock or negedge i_resetN) begin
        if (!i_resetN) begin
            cnt_reg <= '0;
            sck     <= 1'b0;
        end else if (!en) begin
            cnt_reg <= '0;
            sck     <= 1'b0;
        end else begin
            if (cnt_reg == CNT_W'(CLKS_PER_BIT - 1)) begin
                cnt_reg <= '0;
                sck     <= 1'b0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
                if (cnt_reg == CNT_W'(CLKS_PER_BIT / 2 - 1)) begin
                    sck <= 1'b1;
                end
            end
        end
    end

    assign sample_strobe = en && (cnt_reg == CNT_W'(CLKS_PER_BIT / 2));
    assign pre_end       = en && (cnt_reg == CNT_W'(CLKS_PER_BIT - 2));
    assign bit_end       = en && (cnt_reg == CNT_W'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/spi_reg_master.sv
// SPI register-access master: one frame = R/W bit, address, data word(s).
// Optional multi-word bursts are compiled in with the SPI_BURST_EN macro.
module spi_reg_master
    import spi_pkg::*;
#(
    parameter int   ADDR_W       = 7,
    parameter int   DATA_W       = 8,
    parameter int   CLKS_PER_BIT = 30,
    parameter int   CS_GUARD     = 2,
    parameter logic READ_BIT     = 1'b1,
    parameter int   LEN_W        = 4
) (
    input  logic              i_clock,
    input  logic              i_resetN,
    input  logic              i_start,
    input  logic              i_rw,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LEN_W-1:0]  i_len,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_wnext,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_rvalid,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_sen,
    output logic              o_sck,
    output logic              o_sdat,
    input  logic              i_sout
);

    localparam int IDX_MAX = (ADDR_W > DATA_W - 1) ? ADDR_W : DATA_W - 1;
    localparam int IDX_W   = $clog2(IDX_MAX + 1);
    localparam int GUARD_W = (CS_GUARD > 1) ? $clog2(CS_GUARD) : 1;

    state_t              state_reg;
    logic                read_reg;
    logic [ADDR_W:0]     hdr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [DATA_W-1:0]   rx_reg;
    logic [DATA_W-1:0]   rdata_reg;
    logic [IDX_W-1:0]    bit_idx_reg;
    logic [GUARD_W-1:0]  guard_reg;
    logic                sen_reg;
    logic                sdat_reg;
    logic                busy_reg;
    logic                done_reg;
    logic                rvalid_reg;
    logic                last_word;

    logic timer_en;
    logic sample_strobe;
    logic pre_end;
    logic bit_end;

    assign timer_en = (state_reg == ST_HEADER) || (state_reg == ST_DATA);

    spi_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .i_clock      (i_clock),
        .i_resetN     (i_resetN),
        .en           (timer_en),
        .sck          (o_sck),
        .sample_strobe(sample_strobe),
        .pre_end      (pre_end),
        .bit_end      (bit_end)
    );

`ifdef SPI_BURST_EN
    logic [LEN_W-1:0] word_cnt_reg;
    logic             wnext_reg;

    assign last_word = (word_cnt_reg == '0);
    assign o_wnext   = wnext_reg;

    // Burst bookkeeping: words remaining and the request for the next write word.
    // The source sees o_wnext during the last cycle of a word and must present the
    // following word on i_wdata in that same cycle; it is captured at the bit boundary.
    always_ff @(posedge i_clock or negedge i_resetN) begin
        if (!i_resetN) begin
            word_cnt_reg <= '0;
            wnext_reg    <= 1'b0;
        end else begin
            wnext_reg <= pre_end && (state_reg == ST_DATA) && (bit_idx_reg == '0)
                         && !read_reg && (word_cnt_reg != '0);
            if (state_reg == ST_IDLE && i_start) begin
                word_cnt_reg <= i_len;
            end else if (state_reg == ST_DATA && bit_end && bit_idx_reg == '0 && !last_word) begin
                word_cnt_reg <= word_cnt_reg - 1'b1;
            end
        end
    end
`else
    logic unused_burst;
    assign unused_burst = ^{i_len, pre_end};
    assign last_word    = 1'b1;
    assign o_wnext      = 1'b0;
`endif

    // Frame sequencer: chip-select guard, header shift, data shift/capture, closing guard.
    always_ff @(posedge i_clock or negedge i_resetN) begin
        if (!i_resetN) begin
            state_reg   <= ST_IDLE;
            read_reg    <= 1'b0;
            hdr_reg     <= '0;
            wdata_reg   <= '0;
            rx_reg      <= '0;
            rdata_reg   <= '0;
            bit_idx_reg <= '0;
            guard_reg   <= '0;
            sen_reg     <= 1'b1;
            sdat_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            rvalid_reg  <= 1'b0;
        end else begin
            done_reg   <= 1'b0;
            rvalid_reg <= 1'b0;
            if (state_reg == ST_DATA && read_reg && sample_strobe) begin
                rx_reg <= {rx_reg[DATA_W-2:0], i_sout};
            end
            case (state_reg)
                ST_IDLE: begin
                    if (i_start) begin
                        read_reg  <= (i_rw == RW_READ);
                        hdr_reg   <= {(i_rw == RW_READ) ? READ_BIT : ~READ_BIT, i_addr};
                        wdata_reg <= i_wdata;
                        guard_reg <= GUARD_W'(CS_GUARD - 1);
                        sen_reg   <= 1'b0;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (guard_reg == '0) begin
                        state_reg   <= ST_HEADER;
                        bit_idx_reg <= IDX_W'(ADDR_W);
                        sdat_reg    <= hdr_reg[ADDR_W];
                        hdr_reg     <= {hdr_reg[ADDR_W-1:0], 1'b0};
                    end else begin
                        guard_reg <= guard_reg - 1'b1;
                    end
                end
                ST_HEADER: begin
                    if (bit_end) begin
                        if (bit_idx_reg == '0) begin
                            state_reg   <= ST_DATA;
                            bit_idx_reg <= IDX_W'(DATA_W - 1);
                            sdat_reg    <= read_reg ? 1'b0 : wdata_reg[DATA_W-1];
                            wdata_reg   <= {wdata_reg[DATA_W-2:0], 1'b0};
                        end else begin
                            bit_idx_reg <= bit_idx_reg - 1'b1;
                            sdat_reg    <= hdr_reg[ADDR_W];
                            hdr_reg     <= {hdr_reg[ADDR_W-1:0], 1'b0};
                        end
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_idx_reg == '0) begin
                            if (read_reg) begin
                                rdata_reg  <= rx_reg;
                                rvalid_reg <= 1'b1;
                            end
                            if (last_word) begin
                                state_reg <= ST_HOLD;
                                guard_reg <= GUARD_W'(CS_GUARD - 1);
                                sdat_reg  <= 1'b0;
                            end else begin
                                bit_idx_reg <= IDX_W'(DATA_W - 1);
                                sdat_reg    <= read_reg ? 1'b0 : i_wdata[DATA_W-1];
                                wdata_reg   <= {i_wdata[DATA_W-2:0], 1'b0};
                            end
                        end else begin
                            bit_idx_reg <= bit_idx_reg - 1'b1;
                            sdat_reg    <= read_reg ? 1'b0 : wdata_reg[DATA_W-1];
                            wdata_reg   <= {wdata_reg[DATA_W-2:0], 1'b0};
                        end
                    end
                end
                ST_HOLD: begin
                    if (guard_reg == '0) begin
                        state_reg <= ST_DONE;
                        sen_reg   <= 1'b1;
                        done_reg  <= 1'b1;
                    end else begin
                        guard_reg <= guard_reg - 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign o_rdata  = rdata_reg;
    assign o_rvalid = rvalid_reg;
    assign o_busy   = busy_reg;
    assign o_done   = done_reg;
    assign o_sen    = sen_reg;
    assign o_sdat   = sdat_reg;

endmodule

// File: tb/tb_spi_reg_master.sv
// Self-checking bench for spi_reg_master (fast timing: 4 clocks/bit, guard 1).
// Burst scenarios are included when SPI_BURST_EN is defined.
module tb_spi_reg_master;

    localparam int   ADDR_W   = 7;
    localparam int   DATA_W   = 8;
    localparam int   C        = 4;
    localparam int   G        = 1;
    localparam logic READ_BIT = 1'b1;
    localparam int   LEN_W    = 4;

    logic              clk = 1'b0;
    logic              i_resetN;
    logic              i_start;
    logic              i_rw;
    logic [ADDR_W-1:0] i_addr;
    logic [LEN_W-1:0]  i_len;
    logic [DATA_W-1:0] i_wdata;
    logic              o_wnext;
    logic [DATA_W-1:0] o_rdata;
    logic              o_rvalid;
    logic              o_busy;
    logic              o_done;
    logic              o_sen;
    logic              o_sck;
    logic              o_sdat;
    logic              i_sout;

    int vectors = 0;
    int miscompares = 0;

    logic [DATA_W-1:0] wr_words [16];
    logic [DATA_W-1:0] sl_words [16];

    always #5 clk = ~clk;

    spi_reg_master #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .CLKS_PER_BIT(C),
        .CS_GUARD    (G),
        .READ_BIT    (READ_BIT),
        .LEN_W       (LEN_W)
    ) dut (
        .i_clock (clk),
        .i_resetN(i_resetN),
        .i_start (i_start),
        .i_rw    (i_rw),
        .i_addr  (i_addr),
        .i_len   (i_len),
        .i_wdata (i_wdata),
        .o_wnext (o_wnext),
        .o_rdata (o_rdata),
        .o_rvalid(o_rvalid),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_sen   (o_sen),
        .o_sck   (o_sck),
        .o_sdat  (o_sdat),
        .i_sout  (i_sout)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one frame starting at an observation point (#1 after a rising edge).
    // The reference is the frame's serial content and the cycle-accurate event times
    // derived from: N = 1+ADDR_W+words*DATA_W, done at t+2G+N*C+1.
    task automatic run_frame(input logic rw, input logic [ADDR_W-1:0] addr,
                             input int nwords, input bit hold_start);
        int n_bits;
        int done_k;
        int k;
        int rises;
        int done_cnt;
        int rv_cnt;
        int wn_cnt;
        int bad;
        logic prev_sck;
        logic [255:0] exp_vec;
        logic [255:0] got_vec;
        logic slave_bits [$];

        n_bits  = 1 + ADDR_W + nwords * DATA_W;
        done_k  = 2 * G + n_bits * C + 1;
        exp_vec = '0;
        got_vec = '0;
        slave_bits.delete();

        exp_vec = {exp_vec[254:0], rw ? READ_BIT : ~READ_BIT};
        slave_bits.push_back(1'($urandom_range(0, 1)));
        for (int i = ADDR_W - 1; i >= 0; i--) begin
            exp_vec = {exp_vec[254:0], addr[i]};
            slave_bits.push_back(1'($urandom_range(0, 1)));
        end
        for (int w = 0; w < nwords; w++) begin
            for (int j = DATA_W - 1; j >= 0; j--) begin
                exp_vec = {exp_vec[254:0], rw ? 1'b0 : wr_words[w][j]};
                slave_bits.push_back(sl_words[w][j]);
            end
        end

        i_start = 1'b1;
        i_rw    = rw;
        i_addr  = addr;
        i_len   = LEN_W'(nwords - 1);
        i_wdata = wr_words[0];
        k = 0; rises = 0; done_cnt = 0; rv_cnt = 0; wn_cnt = 0; bad = 0;
        prev_sck = 1'b0;

        while (k < done_k + 1) begin
            @(posedge clk); #1;
            k++;
            if (!hold_start) i_start = 1'b0;
            i_sout = (rises < n_bits) ? slave_bits[rises] : 1'b0;
            if (o_sck && !prev_sck) begin
                got_vec = {got_vec[254:0], o_sdat};
                rises++;
            end
            prev_sck = o_sck;
            if (k <= done_k && o_busy !== 1'b1) bad++;
            if (k < done_k && o_sen !== 1'b0) bad++;
            if (o_rvalid) begin
                if (rv_cnt < nwords) begin
                    check("rvalid_cycle", 256'(k),
                          256'(G + (1 + ADDR_W + (rv_cnt + 1) * DATA_W) * C + 1));
                    check("rdata", 256'(o_rdata), 256'(sl_words[rv_cnt]));
                end
                rv_cnt++;
            end
            if (o_wnext) begin
                wn_cnt++;
                if (wn_cnt < nwords) i_wdata = wr_words[wn_cnt];
            end
            if (o_done) begin
                check("done_cycle", 256'(k), 256'(done_k));
                done_cnt++;
            end
        end
        i_sout = 1'b0;

        check("busy_sen_during_frame", 256'(bad), 256'(0));
        check("done_count", 256'(done_cnt), 256'(1));
        check("sck_rises", 256'(rises), 256'(n_bits));
        check("sdat_stream", got_vec, exp_vec);
        check("rvalid_count", 256'(rv_cnt), 256'(rw ? nwords : 0));
        check("wnext_count", 256'(wn_cnt), 256'(rw ? 0 : nwords - 1));
        check("idle_after_done", 256'({o_busy, o_sen}), 256'(2'b01));
        $display("frame rw=%0d addr=%02h words=%0d bits=%0d done_at=t+%0d", rw, addr, nwords, n_bits, done_k);
    endtask

    task automatic randomize_words(input int nwords);
        for (int w = 0; w < 16; w++) begin
            wr_words[w] = DATA_W'($urandom);
            sl_words[w] = DATA_W'($urandom);
        end
        if (nwords < 1) wr_words[0] = '0;
    endtask

    initial begin
        int nw;
        int waited;
        bit seen;

        i_resetN = 1'b0;
        i_start  = 1'b0;
        i_rw     = 1'b0;
        i_addr   = '0;
        i_len    = '0;
        i_wdata  = '0;
        i_sout   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              256'({o_sen, o_sck, o_sdat, o_busy, o_done, o_rvalid, o_wnext, o_rdata}),
              256'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}));
        @(negedge clk);
        i_resetN = 1'b1;
        @(posedge clk); #1;

        // Directed write: addr 0x15, data 0xA5.
        randomize_words(1);
        wr_words[0] = 8'hA5;
        run_frame(1'b0, 7'h15, 1, 1'b0);

        // Directed read: addr 0x2A, slave returns 0x3C.
        randomize_words(1);
        sl_words[0] = 8'h3C;
        run_frame(1'b1, 7'h2A, 1, 1'b0);

        // Randomized frames.
        for (int r = 0; r < 10; r++) begin
`ifdef SPI_BURST_EN
            nw = int'($urandom_range(1, 3));
`else
            nw = 1;
`endif
            randomize_words(nw);
            run_frame(1'($urandom_range(0, 1)), ADDR_W'($urandom), nw, 1'b0);
        end

        // i_start held high for the whole frame including DONE: only one frame,
        // then the request is taken once the master is idle again.
        randomize_words(1);
        run_frame(1'b0, 7'h33, 1, 1'b1);
        @(posedge clk); #1;
        check("restart_after_idle", 256'(o_busy), 256'(1));
        i_start = 1'b0;
        seen = 1'b0;
        waited = 0;
        while (!seen && waited < 200) begin
            @(posedge clk); #1;
            waited++;
            if (o_done) seen = 1'b1;
        end
        check("restart_frame_done", 256'(seen), 256'(1));
        @(posedge clk); #1;
        $display("held-start frame drained after %0d cycles", waited);

        // Asynchronous reset while SCK is high in the data phase.
        i_start = 1'b1;
        i_rw    = 1'b0;
        i_addr  = 7'h55;
        i_wdata = 8'hC3;
        i_len   = '0;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (44) @(posedge clk);
        #2;
        check("sck_high_before_reset", 256'(o_sck), 256'(1));
        i_resetN = 1'b0;
        #1;
        check("async_reset_mid_data", 256'({o_sen, o_sck, o_busy, o_done}), 256'(4'b1000));
        @(negedge clk);
        i_resetN = 1'b1;
        @(posedge clk); #1;
        $display("reset applied mid-data");
        randomize_words(1);
        run_frame(1'b1, 7'h4B, 1, 1'b0);

`ifdef SPI_BURST_EN
        // Burst write of three words and burst read of two.
        randomize_words(3);
        wr_words[0] = 8'h11;
        wr_words[1] = 8'h22;
        wr_words[2] = 8'h33;
        run_frame(1'b0, 7'h10, 3, 1'b0);
        randomize_words(2);
        sl_words[0] = 8'hDE;
        sl_words[1] = 8'hAD;
        run_frame(1'b1, 7'h20, 2, 1'b0);
        randomize_words(16);
        run_frame(1'b0, 7'h7F, 16, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
